// File: rtl/term_line_sched_if.sv
// Terminal line scheduler bus: requesters A/B and the video memory line port.
// master = environment side (requesters, video memory), slave = scheduler.
interface term_line_sched_if #(
  parameter int LINE_W = 512,
  parameter int LEN_W  = 7
);
  logic              a_valid;
  logic              a_last;
  logic [LEN_W-1:0]  a_len;
  logic [LINE_W-1:0] a_line;
  logic              a_ready;
  logic              b_valid;
  logic              b_last;
  logic [LEN_W-1:0]  b_len;
  logic [LINE_W-1:0] b_line;
  logic              b_ready;
  logic              vm_line_ready;
  logic [LEN_W-1:0]  vm_line_len;
  logic [LINE_W-1:0] vm_line;
  logic              vm_line_next;
  logic              vm_solved;
  logic              vm_solved_ack;

  modport master (
    output a_valid, a_last, a_len, a_line,
    input  a_ready,
    output b_valid, b_last, b_len, b_line,
    input  b_ready,
    input  vm_line_ready, vm_line_len, vm_line, vm_solved,
    output vm_line_next, vm_solved_ack
  );

  modport slave (
    input  a_valid, a_last, a_len, a_line,
    output a_ready,
    input  b_valid, b_last, b_len, b_line,
    output b_ready,
    output vm_line_ready, vm_line_len, vm_line, vm_solved,
    input  vm_line_next, vm_solved_ack
  );
endinterface

// File: rtl/term_line_sched.sv
// Two-requester terminal line scheduler feeding the video memory line port.
// Ports: clk, rst (sync, high); bus (slave): A/B line requests, ready
// strobes, vm line offer/next, vm_solved/ack; status: busy, owner,
// err_len, err_tmo (sticky), line_cnt (delivered lines, wrapping).
module term_line_sched #(
  parameter int LINE_W  = 512,
  parameter int LEN_W   = 7,
  parameter int ACK_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  term_line_sched_if.slave bus,
  output logic             busy,
  output logic             owner,
  output logic             err_len,
  output logic             err_tmo,
  output logic [15:0]      line_cnt
);
  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, GAP, SOLVE, WAIT_ACK
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(63);
  localparam logic [7:0]       TMO_LAST = 8'(ACK_TMO - 1);

  state_t            state;
  state_t            state_nx;
  logic              rr_pri;
  logic              last_q;
  logic [7:0]        tmo_cnt;
  logic              own_valid;
  logic              own_last;
  logic [LEN_W-1:0]  own_len;
  logic [LINE_W-1:0] own_line;
  logic              grant;
  logic              line_done;
  logic              tmo_hit;

  always_comb begin
    own_valid = bus.a_valid;
    own_last  = bus.a_last;
    own_len   = bus.a_len;
    own_line  = bus.a_line;
    if (owner) begin
      own_valid = bus.b_valid;
      own_last  = bus.b_last;
      own_len   = bus.b_len;
      own_line  = bus.b_line;
    end
  end

  // Contention goes to rr_pri; otherwise whichever side is asking.
  assign grant = (bus.a_valid && bus.b_valid) ? rr_pri : bus.b_valid;

  // Next only counts once the line is actually on offer.
  assign line_done = (state == SEND) && bus.vm_line_ready
                     && bus.vm_line_next;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (bus.a_valid || bus.b_valid) state_nx = LOAD;
      LOAD:     if (own_valid) state_nx = SEND;
      SEND:     if (line_done) state_nx = GAP;
      GAP:      state_nx = last_q ? SOLVE : LOAD;
      SOLVE:    state_nx = WAIT_ACK;
      WAIT_ACK: if (bus.vm_solved_ack || tmo_hit) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      rr_pri            <= 1'b0;
      owner             <= 1'b0;
      last_q            <= 1'b0;
      tmo_cnt           <= 8'd0;
      busy              <= 1'b0;
      err_len           <= 1'b0;
      err_tmo           <= 1'b0;
      line_cnt          <= 16'd0;
      bus.a_ready       <= 1'b0;
      bus.b_ready       <= 1'b0;
      bus.vm_line_ready <= 1'b0;
      bus.vm_line_len   <= '0;
      bus.vm_line       <= '0;
      bus.vm_solved     <= 1'b0;
    end else begin
      state         <= state_nx;
      busy          <= (state_nx != IDLE);
      bus.a_ready   <= 1'b0;
      bus.b_ready   <= 1'b0;
      bus.vm_solved <= (state_nx == SOLVE);
      // The first SEND cycle carries the ready strobe, so the offer
      // starts one cycle later and never overlaps it.
      bus.vm_line_ready <= (state == SEND) && (state_nx == SEND);
      tmo_cnt <= (state == WAIT_ACK) ? tmo_cnt + 8'd1 : 8'd0;
      unique case (state)
        IDLE: begin
          if (state_nx == LOAD) owner <= grant;
        end
        LOAD: begin
          if (own_valid) begin
            bus.a_ready <= !owner;
            bus.b_ready <= owner;
            last_q      <= own_last;
            bus.vm_line <= own_line;
            if (own_len > MAX_LEN) begin
              bus.vm_line_len <= MAX_LEN;
              err_len         <= 1'b1;
            end else begin
              bus.vm_line_len <= own_len;
            end
          end
        end
        SEND: begin
          if (line_done) line_cnt <= line_cnt + 16'd1;
        end
        WAIT_ACK: begin
          if (state_nx == IDLE) begin
            rr_pri <= !owner;
            if (!bus.vm_solved_ack) err_tmo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
